// File: rtl/avalon_pio_bidir.sv
// avalon_pio_bidir: Avalon-MM parallel I/O port with per-bit direction,
// input synchroniser, sticky edge capture, interrupt mask and level IRQ.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   address[2:0]          register word address
//   chipselect, write_n   write occurs when chipselect & ~write_n
//   writedata[31:0]       write data, bits [WIDTH-1:0] used
//   readdata[31:0]        combinational read data, zero-extended
//   in_port[WIDTH-1:0]    asynchronous pad inputs
//   out_port[WIDTH-1:0]   output data register
//   oe[WIDTH-1:0]         per-bit output enable (direction register)
//   irq                   registered level interrupt
//
// Register map: 0 DATA, 1 DIR, 2 MASK, 3 EDGE (write-1-to-clear),
//   4 OUTSET, 5 OUTCLR (only with PIO_SETCLR_EN), others read 0.
// Build option: define PIO_SETCLR_EN to enable the OUTSET/OUTCLR
//   registers; without it addresses 4 and 5 read 0 and ignore writes.

`timescale 1ns/1ps

module avalon_pio_bidir #(
    parameter int unsigned      WIDTH       = 9,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      EDGE_TYPE   = 0,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam logic [2:0] A_DATA = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_MASK = 3'd2;
    localparam logic [2:0] A_EDGE = 3'd3;
`ifdef PIO_SETCLR_EN
    localparam logic [2:0] A_OSET = 3'd4;
    localparam logic [2:0] A_OCLR = 3'd5;
`endif

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_prev;
    logic             r_irq;

    // Stage 0 samples the pad; stage SYNC_STAGES-1 is the
    // synchronised value used everywhere else.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_sync_in;
    logic [WIDTH-1:0] w_det;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_out_nxt;
    logic [WIDTH-1:0] w_rd;
    logic             w_unused;

    assign w_wr      = chipselect & ~write_n;
    assign w_wd      = writedata[WIDTH-1:0];
    assign w_sync_in = r_sync[SYNC_STAGES-1];
    assign w_unused  = &{1'b0, writedata};

    // Synchroniser chain and one-cycle delayed copy for edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
            r_prev <= w_sync_in;
        end
    end

    generate
        if (EDGE_TYPE == 1) begin : g_fall
            assign w_det = ~w_sync_in & r_prev;
        end else if (EDGE_TYPE == 2) begin : g_any
            assign w_det = w_sync_in ^ r_prev;
        end else begin : g_rise
            assign w_det = w_sync_in & ~r_prev;
        end
    endgenerate

    // Bits written as 1 to EDGE are cleared, but a new edge on the
    // same cycle is OR-ed in afterwards, so the edge wins.
    assign w_clr = (w_wr && (address == A_EDGE)) ? w_wd : '0;

    always_comb begin
        w_out_nxt = r_out;
        if (w_wr && (address == A_DATA)) begin
            w_out_nxt = w_wd;
        end
`ifdef PIO_SETCLR_EN
        if (w_wr && (address == A_OSET)) begin
            w_out_nxt = r_out | w_wd;
        end
        if (w_wr && (address == A_OCLR)) begin
            w_out_nxt = r_out & ~w_wd;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out  <= RESET_VALUE;
            r_dir  <= '0;
            r_mask <= '0;
        end else begin
            r_out <= w_out_nxt;
            if (w_wr && (address == A_DIR)) begin
                r_dir <= w_wd;
            end
            if (w_wr && (address == A_MASK)) begin
                r_mask <= w_wd;
            end
        end
    end

    // irq samples the registered capture/mask, so it trails any
    // change to either by one clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_edge <= (r_edge & ~w_clr) | w_det;
            r_irq  <= |(r_edge & r_mask);
        end
    end

    always_comb begin
        w_rd = '0;
        case (address)
            A_DATA:  w_rd = (r_dir & r_out) | (~r_dir & w_sync_in);
            A_DIR:   w_rd = r_dir;
            A_MASK:  w_rd = r_mask;
            A_EDGE:  w_rd = r_edge;
            default: w_rd = '0;
        endcase
    end

    always_comb begin
        readdata             = '0;
        readdata[WIDTH-1:0]  = w_rd;
    end

    assign out_port = r_out;
    assign oe       = r_dir;
    assign irq      = r_irq;

endmodule
